multicycle_ctrl: RTL and testbench

Multi-cycle control state machine for the RV core. It sequences instruction fetch, decode, execute, memory access and write-back around the opcode classifier. It consumes the classifier's `instr_format` and `instr_type` and drives every datapath strobe: memory request, IR/PC/register-file write enables and mux selects. It also keeps a retired-instruction counter.

---
 rtl/multicycle_ctrl_pkg.sv | 71 +++++++
 rtl/ctrl_outdec.sv | 87 ++++++++
 rtl/multicycle_ctrl.sv | 114 +++++++++++
 tb/tb_multicycle_ctrl.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_ctrl_pkg.sv
`default_nettype none
// multicycle_ctrl_pkg: classifier format/type codes, controller state encoding,
// pc_src/wb_sel codes and the EXEC dispatch helper shared by the controller files.
package multicycle_ctrl_pkg;

  localparam logic [2:0] I_TYPE  = 3'd0;
  localparam logic [2:0] S_TYPE  = 3'd1;
  localparam logic [2:0] R_TYPE  = 3'd2;
  localparam logic [2:0] R4_TYPE = 3'd3;
  localparam logic [2:0] B_TYPE  = 3'd4;
  localparam logic [2:0] U_TYPE  = 3'd5;
  localparam logic [2:0] J_TYPE  = 3'd6;

  // Type codes follow the RV opcode[6:2] field.
  localparam logic [4:0] LOAD      = 5'b00000;
  localparam logic [4:0] OP_IMM    = 5'b00100;
  localparam logic [4:0] OP_IMM_32 = 5'b00110;
  localparam logic [4:0] STORE     = 5'b01000;
  localparam logic [4:0] OP        = 5'b01100;
  localparam logic [4:0] LUI       = 5'b01101;
  localparam logic [4:0] OP_32     = 5'b01110;
  localparam logic [4:0] MADD      = 5'b10000;
  localparam logic [4:0] NMSUB     = 5'b10010;
  localparam logic [4:0] BRANCH    = 5'b11000;
  localparam logic [4:0] JALR      = 5'b11001;
  localparam logic [4:0] JAL       = 5'b11011;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd5
  } state_e;

  localparam logic [1:0] PC_PLUS4  = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_JAL    = 2'b10;
  localparam logic [1:0] PC_JALR   = 2'b11;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;
  localparam logic [1:0] WB_IMM = 2'b11;

  typedef enum logic [1:0] {
    EX_MEM    = 2'd0,
    EX_WB     = 2'd1,
    EX_BRANCH = 2'd2,
    EX_OTHER  = 2'd3
  } exec_class_e;

  // Anything not recognised takes the MADD/NMSUB path (NOP or trap).
  function automatic exec_class_e exec_class(input logic [4:0] t);
    exec_class_e c;
    case (t)
      LOAD, STORE:                                 c = EX_MEM;
      BRANCH:                                      c = EX_BRANCH;
      OP, OP_IMM, OP_32, OP_IMM_32, LUI, JAL, JALR: c = EX_WB;
      default:                                     c = EX_OTHER;
    endcase
    return c;
  endfunction

  function automatic logic uses_imm(input logic [2:0] fmt);
    return (fmt == I_TYPE) || (fmt == S_TYPE) || (fmt == U_TYPE) || (fmt == J_TYPE);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ctrl_outdec.sv
`default_nettype none
// ctrl_outdec: combinational strobe decode for multicycle_ctrl.
// With CTRL_TRAP_EN defined, unsupported EXEC types retire nothing (controller traps).
module ctrl_outdec
  import multicycle_ctrl_pkg::*;
(
  input  logic [2:0] state,
  input  logic [4:0] type_q,
  input  logic [2:0] fmt_q,
  input  logic       mem_ready,
  input  logic       br_taken,
  output logic       mem_req,
  output logic       mem_we,
  output logic       mem_sel_instr,
  output logic       ir_we,
  output logic       pc_we,
  output logic [1:0] pc_src,
  output logic       alu_src_imm,
  output logic       reg_we,
  output logic [1:0] wb_sel,
  output logic       retire
);

  always_comb begin
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    mem_sel_instr = 1'b0;
    ir_we         = 1'b0;
    pc_we         = 1'b0;
    pc_src        = PC_PLUS4;
    alu_src_imm   = 1'b0;
    reg_we        = 1'b0;
    wb_sel        = WB_ALU;
    retire        = 1'b0;
    case (state)
      ST_FETCH: begin
        mem_req       = 1'b1;
        mem_sel_instr = 1'b1;
        ir_we         = mem_ready;
      end
      ST_EXEC: begin
        alu_src_imm = uses_imm(fmt_q);
        case (exec_class(type_q))
          EX_BRANCH: begin
            pc_we  = 1'b1;
            pc_src = br_taken ? PC_BRANCH : PC_PLUS4;
            retire = 1'b1;
          end
          EX_OTHER: begin
`ifndef CTRL_TRAP_EN
            pc_we  = 1'b1;
            retire = 1'b1;
`endif
          end
          default: ;
        endcase
      end
      ST_MEM: begin
        mem_req = 1'b1;
        mem_we  = (type_q == STORE);
        if (mem_ready && (type_q == STORE)) begin
          pc_we  = 1'b1;
          retire = 1'b1;
        end
      end
      ST_WB: begin
        reg_we = 1'b1;
        pc_we  = 1'b1;
        retire = 1'b1;
        case (type_q)
          LOAD:      wb_sel = WB_MEM;
          JAL, JALR: wb_sel = WB_PC4;
          LUI:       wb_sel = WB_IMM;
          default:   wb_sel = WB_ALU;
        endcase
        case (type_q)
          JAL:     pc_src = PC_JAL;
          JALR:    pc_src = PC_JALR;
          default: pc_src = PC_PLUS4;
        endcase
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/multicycle_ctrl.sv
`default_nettype none
// multicycle_ctrl: FETCH/DECODE/EXEC/MEM/WB sequencer with retired-instruction counter.
// Define CTRL_TRAP_EN to add the TRAP state and sticky trap output for MADD/NMSUB.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [2:0]       instr_format,
  input  logic [4:0]       instr_type,
  input  logic             mem_ready,
  input  logic             br_taken,
  output logic             mem_req,
  output logic             mem_we,
  output logic             mem_sel_instr,
  output logic             ir_we,
  output logic             pc_we,
  output logic [1:0]       pc_src,
  output logic             alu_src_imm,
  output logic             reg_we,
  output logic [1:0]       wb_sel,
  output logic [2:0]       state,
  output logic             retire,
`ifdef CTRL_TRAP_EN
  output logic             trap,
`endif
  output logic [CNT_W-1:0] instret
);

  state_e           state_q, state_d;
  logic [4:0]       type_q, type_d;
  logic [2:0]       fmt_q, fmt_d;
  logic [CNT_W-1:0] instret_q, instret_d;
  logic             dec_mem_req, dec_mem_sel_instr, dec_ir_we;

  ctrl_outdec u_outdec (
    .state         (state_q),
    .type_q        (type_q),
    .fmt_q         (fmt_q),
    .mem_ready     (mem_ready),
    .br_taken      (br_taken),
    .mem_req       (dec_mem_req),
    .mem_we        (mem_we),
    .mem_sel_instr (dec_mem_sel_instr),
    .ir_we         (dec_ir_we),
    .pc_we         (pc_we),
    .pc_src        (pc_src),
    .alu_src_imm   (alu_src_imm),
    .reg_we        (reg_we),
    .wb_sel        (wb_sel),
    .retire        (retire)
  );

  // FETCH is the reset state, so its strobes must be masked while reset is held.
  assign mem_req       = dec_mem_req & RST_N;
  assign mem_sel_instr = dec_mem_sel_instr & RST_N;
  assign ir_we         = dec_ir_we & RST_N;
  assign state         = state_q;
  assign instret       = instret_q;
`ifdef CTRL_TRAP_EN
  assign trap          = (state_q == ST_TRAP);
`endif

  always_comb begin
    state_d   = state_q;
    type_d    = type_q;
    fmt_d     = fmt_q;
    instret_d = instret_q + {{(CNT_W-1){1'b0}}, retire};
    case (state_q)
      ST_FETCH: if (mem_ready) state_d = ST_DECODE;
      ST_DECODE: begin
        type_d  = instr_type;
        fmt_d   = instr_format;
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        case (exec_class(type_q))
          EX_MEM:    state_d = ST_MEM;
          EX_WB:     state_d = ST_WB;
          EX_BRANCH: state_d = ST_FETCH;
`ifdef CTRL_TRAP_EN
          default:   state_d = ST_TRAP;
`else
          default:   state_d = ST_FETCH;
`endif
        endcase
      end
      ST_MEM: if (mem_ready) state_d = (type_q == STORE) ? ST_FETCH : ST_WB;
      ST_WB: state_d = ST_FETCH;
`ifdef CTRL_TRAP_EN
      ST_TRAP: state_d = ST_TRAP;
`endif
      default: state_d = ST_FETCH;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= ST_FETCH;
      type_q    <= '0;
      fmt_q     <= '0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      type_q    <= type_d;
      fmt_q     <= fmt_d;
      instret_q <= instret_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
`default_nettype none
// Bench for multicycle_ctrl: expected per-cycle strobes/state/instret queued per instruction.
module tb_multicycle_ctrl;
  import multicycle_ctrl_pkg::*;

  localparam int   CW = 3;
  localparam logic T  = 1'b1;
  localparam logic F  = 1'b0;

  logic          CLK = 1'b0;
  logic          RST_N;
  logic [2:0]    instr_format;
  logic [4:0]    instr_type;
  logic          mem_ready, br_taken;
  logic          mem_req, mem_we, mem_sel_instr, ir_we, pc_we, alu_src_imm, reg_we, retire;
  logic [1:0]    pc_src, wb_sel;
  logic [2:0]    state;
  logic [CW-1:0] instret;
  logic          trap_w;
  logic [CW+15:0] obs;

  typedef struct {
    logic           rdy;
    logic           bt;
    logic [4:0]     typ;
    logic [2:0]     fmt;
    logic [CW+15:0] exp;
  } cyc_t;

  cyc_t          sq[$];
  logic [CW-1:0] model_cnt;
  int            n_pass  = 0;
  int            n_total = 0;

  always #5 CLK = ~CLK;

  multicycle_ctrl #(.CNT_W(CW)) dut (
    .CLK           (CLK),
    .RST_N         (RST_N),
    .instr_format  (instr_format),
    .instr_type    (instr_type),
    .mem_ready     (mem_ready),
    .br_taken      (br_taken),
    .mem_req       (mem_req),
    .mem_we        (mem_we),
    .mem_sel_instr (mem_sel_instr),
    .ir_we         (ir_we),
    .pc_we         (pc_we),
    .pc_src        (pc_src),
    .alu_src_imm   (alu_src_imm),
    .reg_we        (reg_we),
    .wb_sel        (wb_sel),
    .state         (state),
    .retire        (retire),
`ifdef CTRL_TRAP_EN
    .trap          (trap_w),
`endif
    .instret       (instret)
  );

`ifndef CTRL_TRAP_EN
  assign trap_w = 1'b0;
`endif

  assign obs = {instret, trap_w, state, mem_req, mem_we, mem_sel_instr, ir_we, pc_we,
                pc_src, alu_src_imm, reg_we, wb_sel, retire};

  function automatic logic rb();
    return 1'($urandom_range(1, 0));
  endfunction

  function automatic logic [15:0] mk(input logic [2:0] st, input logic req, we, sel, ir, pcw,
                                     input logic [1:0] pcs, input logic imm, rw,
                                     input logic [1:0] wbs, input logic ret, trp);
    return {trp, st, req, we, sel, ir, pcw, pcs, imm, rw, wbs, ret};
  endfunction

  task automatic push(input logic rdy, input logic bt, input logic [4:0] typ,
                      input logic [2:0] fmt, input logic [15:0] e);
    cyc_t c;
    c.rdy = rdy; c.bt = bt; c.typ = typ; c.fmt = fmt; c.exp = {model_cnt, e};
    sq.push_back(c);
    if (e[0]) model_cnt = model_cnt + 1'b1;
  endtask

  // Reference model: one instruction expanded into its expected cycle sequence.
  task automatic push_instr(input logic [4:0] typ, input logic [2:0] fmt,
                            input int fw, input int mw, input logic bt);
    logic imm, isst, ismem, iswb;
    logic [1:0] pcs, wbs;
    imm   = (fmt == I_TYPE) || (fmt == S_TYPE) || (fmt == U_TYPE) || (fmt == J_TYPE);
    isst  = (typ == STORE);
    ismem = isst || (typ == LOAD);
    iswb  = (typ == OP) || (typ == OP_IMM) || (typ == OP_32) || (typ == OP_IMM_32) ||
            (typ == LUI) || (typ == JAL) || (typ == JALR) || (typ == LOAD);
    pcs   = (typ == JAL) ? 2'b10 : (typ == JALR) ? 2'b11 : 2'b00;
    wbs   = (typ == LOAD) ? 2'b01 : ((typ == JAL) || (typ == JALR)) ? 2'b10 :
            (typ == LUI) ? 2'b11 : 2'b00;
    for (int i = 0; i < fw; i++) push(F, rb(), typ, fmt, mk(3'd0, T, F, T, F, F, 2'b00, F, F, 2'b00, F, F));
    push(T, rb(), typ, fmt, mk(3'd0, T, F, T, T, F, 2'b00, F, F, 2'b00, F, F));
    push(rb(), rb(), typ, fmt, mk(3'd1, F, F, F, F, F, 2'b00, F, F, 2'b00, F, F));
    if (typ == BRANCH)
      push(rb(), bt, typ, fmt, mk(3'd2, F, F, F, F, T, {1'b0, bt}, imm, F, 2'b00, T, F));
    else if (iswb || ismem)
      push(rb(), bt, typ, fmt, mk(3'd2, F, F, F, F, F, 2'b00, imm, F, 2'b00, F, F));
    else begin
`ifdef CTRL_TRAP_EN
      push(rb(), bt, typ, fmt, mk(3'd2, F, F, F, F, F, 2'b00, imm, F, 2'b00, F, F));
      for (int i = 0; i < 3; i++) push(rb(), rb(), typ, fmt, mk(3'd5, F, F, F, F, F, 2'b00, F, F, 2'b00, F, T));
`else
      push(rb(), bt, typ, fmt, mk(3'd2, F, F, F, F, T, 2'b00, imm, F, 2'b00, T, F));
`endif
    end
    if (ismem) begin
      for (int i = 0; i < mw; i++) push(F, rb(), typ, fmt, mk(3'd3, T, isst, F, F, F, 2'b00, F, F, 2'b00, F, F));
      push(T, rb(), typ, fmt, mk(3'd3, T, isst, F, F, isst, 2'b00, F, F, 2'b00, isst, F));
    end
    if (iswb) push(rb(), rb(), typ, fmt, mk(3'd4, F, F, F, F, T, pcs, F, T, wbs, T, F));
  endtask

  task automatic test_reset();
    model_cnt = '0;
    RST_N = 1'b0; mem_ready = 1'b1; br_taken = 1'b0; instr_type = OP; instr_format = R_TYPE;
    #1;
    n_total++;
    if (obs !== '0) $display("FAIL reset_async: got %h expected %h", obs, {(CW+16){1'b0}});
    else n_pass++;
    @(posedge CLK); #1;
    n_total++;
    if (obs !== '0) $display("FAIL reset_held: got %h expected %h", obs, {(CW+16){1'b0}});
    else n_pass++;
    @(negedge CLK);
    mem_ready = 1'b0; RST_N = 1'b1;
    #1;
    n_total++;
    if (obs !== {model_cnt, mk(3'd0, T, F, T, F, F, 2'b00, F, F, 2'b00, F, F)})
      $display("FAIL reset_release: got %h expected %h", obs,
               {model_cnt, mk(3'd0, T, F, T, F, F, 2'b00, F, F, 2'b00, F, F)});
    else n_pass++;
    @(posedge CLK); #1;
  endtask

  task automatic test_alu();
    cyc_t c; int cyc = 0;
    push_instr(OP, R_TYPE, 0, 0, F);
    push_instr(OP_IMM, I_TYPE, 0, 0, F);
    while (sq.size() > 0) begin
      c = sq.pop_front();
      mem_ready = c.rdy; br_taken = c.bt; instr_type = c.typ; instr_format = c.fmt;
      @(negedge CLK);
      n_total++;
      if (obs !== c.exp) $display("FAIL alu cycle %0d: got %h expected %h", cyc, obs, c.exp);
      else n_pass++;
      cyc++;
      @(posedge CLK); #1;
    end
  endtask

  task automatic test_load_wait();
    cyc_t c; int cyc = 0;
    push_instr(LOAD, I_TYPE, 0, 2, F);
    while (sq.size() > 0) begin
      c = sq.pop_front();
      mem_ready = c.rdy; br_taken = c.bt; instr_type = c.typ; instr_format = c.fmt;
      @(negedge CLK);
      n_total++;
      if (obs !== c.exp) $display("FAIL load_wait cycle %0d: got %h expected %h", cyc, obs, c.exp);
      else n_pass++;
      cyc++;
      @(posedge CLK); #1;
    end
  endtask

  task automatic test_store();
    cyc_t c; int cyc = 0;
    push_instr(STORE, S_TYPE, 1, 1, F);
    push_instr(STORE, S_TYPE, 0, 0, F);
    while (sq.size() > 0) begin
      c = sq.pop_front();
      mem_ready = c.rdy; br_taken = c.bt; instr_type = c.typ; instr_format = c.fmt;
      @(negedge CLK);
      n_total++;
      if (obs !== c.exp) $display("FAIL store cycle %0d: got %h expected %h", cyc, obs, c.exp);
      else n_pass++;
      cyc++;
      @(posedge CLK); #1;
    end
  endtask

  task automatic test_branch();
    cyc_t c; int cyc = 0;
    push_instr(BRANCH, B_TYPE, 0, 0, T);
    push_instr(BRANCH, B_TYPE, 0, 0, F);
    while (sq.size() > 0) begin
      c = sq.pop_front();
      mem_ready = c.rdy; br_taken = c.bt; instr_type = c.typ; instr_format = c.fmt;
      @(negedge CLK);
      n_total++;
      if (obs !== c.exp) $display("FAIL branch cycle %0d: got %h expected %h", cyc, obs, c.exp);
      else n_pass++;
      cyc++;
      @(posedge CLK); #1;
    end
  endtask

  task automatic test_jalr_lui();
    cyc_t c; int cyc = 0;
    push_instr(JALR, I_TYPE, 0, 0, F);
    push_instr(LUI, U_TYPE, 0, 0, F);
    push_instr(JAL, J_TYPE, 0, 0, F);
    while (sq.size() > 0) begin
      c = sq.pop_front();
      mem_ready = c.rdy; br_taken = c.bt; instr_type = c.typ; instr_format = c.fmt;
      @(negedge CLK);
      n_total++;
      if (obs !== c.exp) $display("FAIL jalr_lui cycle %0d: got %h expected %h", cyc, obs, c.exp);
      else n_pass++;
      cyc++;
      @(posedge CLK); #1;
    end
  endtask

  task automatic test_back_to_back();
    cyc_t c; int cyc = 0;
    push_instr(OP_32, R_TYPE, 0, 0, F);
    push_instr(OP_IMM_32, I_TYPE, 1, 0, F);
    push_instr(LOAD, I_TYPE, 2, 0, F);
    push_instr(STORE, S_TYPE, 0, 3, F);
    push_instr(BRANCH, B_TYPE, 0, 0, T);
    push_instr(JAL, J_TYPE, 0, 0, F);
    push_instr(OP, R_TYPE, 0, 0, F);
    push_instr(LUI, U_TYPE, 0, 0, F);
    push_instr(LOAD, I_TYPE, 0, 0, F);
    while (sq.size() > 0) begin
      c = sq.pop_front();
      mem_ready = c.rdy; br_taken = c.bt; instr_type = c.typ; instr_format = c.fmt;
      @(negedge CLK);
      n_total++;
      if (obs !== c.exp) $display("FAIL back_to_back cycle %0d: got %h expected %h", cyc, obs, c.exp);
      else n_pass++;
      cyc++;
      @(posedge CLK); #1;
    end
  endtask

  task automatic test_reset_mid();
    mem_ready = 1'b0;
    @(negedge CLK);
    n_total++;
    if (obs !== {model_cnt, mk(3'd0, T, F, T, F, F, 2'b00, F, F, 2'b00, F, F)})
      $display("FAIL reset_mid_pre: got %h expected %h", obs,
               {model_cnt, mk(3'd0, T, F, T, F, F, 2'b00, F, F, 2'b00, F, F)});
    else n_pass++;
    RST_N = 1'b0;
    #1;
    n_total++;
    if (obs !== '0) $display("FAIL reset_mid_drop: got %h expected %h", obs, {(CW+16){1'b0}});
    else n_pass++;
    #1;
    RST_N = 1'b1;
    model_cnt = '0;
    #1;
    n_total++;
    if (obs !== {model_cnt, mk(3'd0, T, F, T, F, F, 2'b00, F, F, 2'b00, F, F)})
      $display("FAIL reset_mid_release: got %h expected %h", obs,
               {model_cnt, mk(3'd0, T, F, T, F, F, 2'b00, F, F, 2'b00, F, F)});
    else n_pass++;
    @(posedge CLK); #1;
  endtask

  task automatic test_madd();
    cyc_t c; int cyc = 0;
    logic [4:0] ops [2];
    ops[0] = MADD; ops[1] = NMSUB;
    for (int k = 0; k < 2; k++) begin
      push_instr(ops[k], R4_TYPE, 0, 0, F);
`ifndef CTRL_TRAP_EN
      push_instr(OP, R_TYPE, 0, 0, F);
`endif
      while (sq.size() > 0) begin
        c = sq.pop_front();
        mem_ready = c.rdy; br_taken = c.bt; instr_type = c.typ; instr_format = c.fmt;
        @(negedge CLK);
        n_total++;
        if (obs !== c.exp) $display("FAIL madd cycle %0d: got %h expected %h", cyc, obs, c.exp);
        else n_pass++;
        cyc++;
        @(posedge CLK); #1;
      end
`ifdef CTRL_TRAP_EN
      RST_N = 1'b0; mem_ready = 1'b0;
      #1;
      n_total++;
      if (obs !== '0) $display("FAIL trap_reset: got %h expected %h", obs, {(CW+16){1'b0}});
      else n_pass++;
      #2;
      RST_N = 1'b1;
      model_cnt = '0;
      @(posedge CLK); #1;
`endif
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load_wait();
    test_store();
    test_branch();
    test_jalr_lui();
    test_back_to_back();
    test_reset_mid();
    test_madd();
    test_alu();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
